// File: rtl/wb_j1_data_arbiter_pkg.sv
// Shared definitions for the j1 data-bus arbiter: bus widths, FSM encoding and
// the round-robin index wrap helper.
package wb_j1_data_arbiter_pkg;

  localparam int DataWidth   = 32;
  localparam int CpuNumWidth = 2;
  localparam int WdWidth     = 16;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUS  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/wb_j1_data_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after rr.
// Shared with the instruction-fetch arbiter.
module rr_arbiter_pick
  import wb_j1_data_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] rr,
  output logic [SEL_W-1:0] grant,
  output logic             valid
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = SEL_W'(rr_wrap(int'(rr), i, N));
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_j1_data_arbiter.sv
// Round-robin arbiter sharing one Wishbone data slave between NUM_CPU j1 cores,
// with a watchdog that force-completes accesses the slave never acknowledges.
module wb_j1_data_arbiter
  import wb_j1_data_arbiter_pkg::*;
#(
  parameter int                   NUM_CPU      = 4,
  parameter int                   SEL_W        = CpuNumWidth,
  parameter int                   TIMEOUT_CYC  = 255,
  parameter logic [DataWidth-1:0] TIMEOUT_DATA = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CPU-1:0]             m_cyc_i,
  input  logic [NUM_CPU-1:0]             m_we_i,
  input  logic [NUM_CPU*DataWidth-1:0]   m_adr_i,
  input  logic [NUM_CPU*DataWidth-1:0]   m_dat_i,
  output logic [DataWidth-1:0]           m_dat_o,
  output logic [NUM_CPU-1:0]             m_ack_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [DataWidth-1:0]           s_adr_o,
  output logic [DataWidth-1:0]           s_dat_o,
  input  logic [DataWidth-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  output logic [SEL_W-1:0]               grant_o,
  output logic                           busy_o,
  output logic                           timeout_o,
  output logic [1:0]                     dbg_state_o
);

  // Handshake: a core raises m_cyc_i with stable we/adr/dat and holds it until
  // it sees its one-cycle m_ack_o; toward the slave, s_cyc_o/s_stb_o and the
  // latched payload stay stable until s_ack_i is sampled high (or the watchdog
  // fires), and the access completes on that edge.

  logic [1:0]           state_q;
  logic [SEL_W-1:0]     rr_q;
  logic [WdWidth-1:0]   wd_q;
  logic [SEL_W-1:0]     pick_grant;
  logic                 pick_valid;
  logic [SEL_W-1:0]     next_rr;
  logic                 granted_cyc;
  logic                 timeout_hit;
  logic [DataWidth-1:0] adr_slot [NUM_CPU];
  logic [DataWidth-1:0] dat_slot [NUM_CPU];

  for (genvar k = 0; k < NUM_CPU; k++) begin : g_slot
    assign adr_slot[k] = m_adr_i[DataWidth*k +: DataWidth];
    assign dat_slot[k] = m_dat_i[DataWidth*k +: DataWidth];
  end

  rr_arbiter_pick #(
    .N     (NUM_CPU),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (m_cyc_i),
    .rr    (rr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign next_rr     = (grant_o == SEL_W'(NUM_CPU - 1)) ? '0 : grant_o + SEL_W'(1);
  assign granted_cyc = m_cyc_i[grant_o];
  assign timeout_hit = (wd_q == WdWidth'(TIMEOUT_CYC));
  assign s_stb_o     = s_cyc_o;
  assign busy_o      = (state_q != ARB_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_q      <= '0;
      wd_q      <= '0;
      grant_o   <= '0;
      s_cyc_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      m_dat_o   <= '0;
      m_ack_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      m_ack_o   <= '0;
      timeout_o <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_o <= pick_grant;
            s_we_o  <= m_we_i[pick_grant];
            s_adr_o <= adr_slot[pick_grant];
            s_dat_o <= dat_slot[pick_grant];
            s_cyc_o <= 1'b1;
            wd_q    <= '0;
            state_q <= ARB_BUS;
          end
        end
        ARB_BUS: begin
          // A real ack wins over both the watchdog and a core abort.
          if (s_ack_i) begin
            m_dat_o <= s_dat_i;
            s_cyc_o <= 1'b0;
            m_ack_o <= NUM_CPU'(1) << grant_o;
            state_q <= ARB_RESP;
          end else if (timeout_hit) begin
            m_dat_o   <= TIMEOUT_DATA;
            s_cyc_o   <= 1'b0;
            m_ack_o   <= NUM_CPU'(1) << grant_o;
            timeout_o <= 1'b1;
            state_q   <= ARB_RESP;
          end else if (!granted_cyc) begin
            s_cyc_o <= 1'b0;
            rr_q    <= next_rr;
            wd_q    <= '0;
            state_q <= ARB_IDLE;
          end else if (wd_q != {WdWidth{1'b1}}) begin
            wd_q <= wd_q + WdWidth'(1);
          end
        end
        ARB_RESP: begin
          rr_q    <= next_rr;
          wd_q    <= '0;
          state_q <= ARB_IDLE;
        end
        default: begin
          s_cyc_o <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_j1_data_arbiter.sv
// Randomized and directed bench for wb_j1_data_arbiter against a transaction-level
// round-robin model with an expected-ack queue.
module tb_wb_j1_data_arbiter;

  localparam int NUM_CPU = 4;

  logic                 clk;
  logic                 rst;
  logic [NUM_CPU-1:0]   m_cyc_i;
  logic [NUM_CPU-1:0]   m_we_i;
  logic [NUM_CPU*32-1:0] m_adr_i;
  logic [NUM_CPU*32-1:0] m_dat_i;
  logic [31:0]          m_dat_o;
  logic [NUM_CPU-1:0]   m_ack_o;
  logic                 s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [31:0]          s_adr_o;
  logic [31:0]          s_dat_o;
  logic [31:0]          s_dat_i;
  logic                 s_ack_i;
  logic [1:0]           grant_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic [1:0]           dbg_state_o;

  wb_j1_data_arbiter #(
    .NUM_CPU      (NUM_CPU),
    .SEL_W        (2),
    .TIMEOUT_CYC  (8),
    .TIMEOUT_DATA (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_cyc_i     (m_cyc_i),
    .m_we_i      (m_we_i),
    .m_adr_i     (m_adr_i),
    .m_dat_i     (m_dat_i),
    .m_dat_o     (m_dat_o),
    .m_ack_o     (m_ack_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_dat_i     (s_dat_i),
    .s_ack_i     (s_ack_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          rr_m = 0;
  logic [39:0] exp_q[$];   // {timeout, grant[6:0], data[31:0]}
  logic [3:0]  prev_ack = '0;
  logic        we_a  [NUM_CPU];
  logic [31:0] adr_a [NUM_CPU];
  logic [31:0] dat_a [NUM_CPU];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference rule: first requester at or after rr, wrapping modulo NUM_CPU.
  function automatic logic [1:0] model_pick(input logic [3:0] req, input int rr);
    logic [1:0] idx;
    for (int i = 0; i < NUM_CPU; i++) begin
      idx = 2'((rr + i) % NUM_CPU);
      if (req[idx]) return idx;
    end
    return 2'(rr);
  endfunction

  // driver tasks
  task automatic set_slot(input logic [1:0] k, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat);
    we_a[k]  = we;
    adr_a[k] = adr;
    dat_a[k] = dat;
    m_we_i[k] = we;
    m_adr_i[32*int'(k) +: 32] = adr;
    m_dat_i[32*int'(k) +: 32] = dat;
    m_cyc_i[k] = 1'b1;
  endtask

  // Called with the DUT idle just after a clock edge and at least one request up.
  task automatic run_txn(input int waits, input logic [31:0] rdata, input bit drop);
    logic [1:0] g;
    g = model_pick(m_cyc_i, rr_m);
    exp_q.push_back({1'b0, 7'(g), rdata});
    @(posedge clk); #1;
    check("bus_cyc", 64'(s_cyc_o), 64'(1));
    check("bus_stb", 64'(s_stb_o), 64'(1));
    check("bus_grant", 64'(grant_o), 64'(g));
    check("bus_we", 64'(s_we_o), 64'(we_a[g]));
    check("bus_adr", 64'(s_adr_o), 64'(adr_a[g]));
    check("bus_dat", 64'(s_dat_o), 64'(dat_a[g]));
    check("bus_busy", 64'(busy_o), 64'(1));
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1;
      check("wait_cyc", 64'(s_cyc_o), 64'(1));
      check("wait_adr", 64'(s_adr_o), 64'(adr_a[g]));
      check("wait_dat", 64'(s_dat_o), 64'(dat_a[g]));
    end
    s_dat_i = rdata;
    s_ack_i = 1'b1;
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    s_dat_i = $urandom;
    check("resp_cyc", 64'(s_cyc_o), 64'(0));
    check("resp_busy", 64'(busy_o), 64'(1));
    if (drop) m_cyc_i[g] = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy_o), 64'(0));
    rr_m = (int'(g) + 1) % NUM_CPU;
  endtask

  // scoreboard: every ack must match the head of the expected queue
  always @(negedge clk) begin
    if (m_ack_o != '0) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 64'(m_ack_o), 64'(0));
      end else begin
        check("ack_onehot", 64'(m_ack_o), 64'(4'b0001 << exp_q[0][33:32]));
        check("ack_data", 64'(m_dat_o), 64'(exp_q[0][31:0]));
        check("ack_grant", 64'(grant_o), 64'(exp_q[0][33:32]));
        check("ack_tmo", 64'(timeout_o), 64'(exp_q[0][39]));
        void'(exp_q.pop_front());
      end
      if (prev_ack != '0) check("ack_len", 64'(prev_ack), 64'(0));
    end else if (timeout_o) begin
      check("tmo_stray", 64'(timeout_o), 64'(0));
    end
    prev_ack <= m_ack_o;
  end

  initial begin
    logic [1:0] g;
    rst = 1'b0;
    m_cyc_i = '0;
    m_we_i = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    for (int k = 0; k < NUM_CPU; k++) begin
      we_a[k] = 1'b0; adr_a[k] = '0; dat_a[k] = '0;
    end
    #1 rst = 1'b1;
    #1;
    check("rst_cyc", 64'(s_cyc_o), 64'(0));
    check("rst_ack", 64'(m_ack_o), 64'(0));
    check("rst_dat", 64'(m_dat_o), 64'(0));
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_state", 64'(dbg_state_o), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_adr", 64'(s_adr_o), 64'(0));
    check("rst_tmo", 64'(timeout_o), 64'(0));

    // contention: everyone requesting, 0-wait slave -> 0,1,2,3,0
    for (int k = 0; k < NUM_CPU; k++) set_slot(2'(k), 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int t = 0; t < 5; t++) begin
      check("rr_order", 64'(model_pick(m_cyc_i, rr_m)), 64'(t % NUM_CPU));
      run_txn(0, $urandom, 1'b0);
    end
    for (int t = 0; t < 8 && m_cyc_i != '0; t++) run_txn(0, $urandom, 1'b1);

    // single read from core 2 with two wait states
    set_slot(2'd2, 1'b0, 32'h0000_0100, 32'h0);
    run_txn(2, 32'hCAFE_F00D, 1'b1);

    // write from core 1
    set_slot(2'd1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    run_txn(1, 32'h5A5A_0001, 1'b1);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < NUM_CPU; k++)
        if (!m_cyc_i[k] && $urandom_range(0, 2) == 0)
          set_slot(2'(k), 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (m_cyc_i == '0)
        set_slot(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      run_txn(int'($urandom_range(0, 3)), $urandom, 1'b1);
    end
    for (int t = 0; t < 8 && m_cyc_i != '0; t++) run_txn(0, $urandom, 1'b1);

    // timeout: slave never acks, TIMEOUT_CYC = 8
    set_slot(2'd3, 1'b0, 32'h0000_0300, 32'h0);
    g = model_pick(m_cyc_i, rr_m);
    exp_q.push_back({1'b1, 7'(g), 32'h0000_0000});
    s_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("tmo_start", 64'(s_cyc_o), 64'(1));
    check("tmo_grant", 64'(grant_o), 64'(g));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("tmo_wait", 64'(s_cyc_o), 64'(1));
    end
    @(posedge clk); #1;
    check("tmo_fire", 64'(timeout_o), 64'(1));
    check("tmo_drop", 64'(s_cyc_o), 64'(0));
    m_cyc_i[g] = 1'b0;
    @(posedge clk); #1;
    check("tmo_pulse", 64'(timeout_o), 64'(0));
    check("tmo_idle", 64'(busy_o), 64'(0));
    rr_m = (int'(g) + 1) % NUM_CPU;

    // asynchronous reset in the middle of a bus cycle
    set_slot(2'd2, 1'b1, 32'h0000_0440, 32'h0BAD_0BAD);
    @(posedge clk); #1;
    check("mid_cyc", 64'(s_cyc_o), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_cyc", 64'(s_cyc_o), 64'(0));
    check("arst_we", 64'(s_we_o), 64'(0));
    check("arst_adr", 64'(s_adr_o), 64'(0));
    check("arst_grant", 64'(grant_o), 64'(0));
    check("arst_busy", 64'(busy_o), 64'(0));
    m_cyc_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m = 0;

    // abort: core 0 gives up mid-access, core 1 is next
    set_slot(2'd0, 1'b0, 32'h0000_0010, 32'h0);
    set_slot(2'd1, 1'b0, 32'h0000_0014, 32'h0);
    @(posedge clk); #1;
    check("abort_grant", 64'(grant_o), 64'(0));
    check("abort_cyc_up", 64'(s_cyc_o), 64'(1));
    m_cyc_i[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_cyc_dn", 64'(s_cyc_o), 64'(0));
    check("abort_idle", 64'(busy_o), 64'(0));
    rr_m = 1;
    run_txn(1, 32'h7777_1111, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_j1_data_arbiter.md
Name: wb_j1_data_arbiter

Overview:
Shared data-bus arbiter between N j1 CPU cores and a single Wishbone data slave (shared data RAM / peripheral fabric).
Each core's data port (cyc/we/adr/dat out, dat/ack in) attaches to one master slot. The arbiter grants one core at a time in round-robin order, forwards the access to the slave and returns read data with a one-cycle ack.
A watchdog terminates accesses the slave never acknowledges, so no core stalls forever.

Parameters:
NUM_CPU, 4, number of master slots (2..8)
SEL_W, 2, width of grant index (clog2(NUM_CPU))
TIMEOUT_CYC, 255, slave wait cycles before forced termination (1..65535)
TIMEOUT_DATA, 32'h0000_0000, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m_cyc_i  in  NUM_CPU  per-core request (level, held until ack)
m_we_i  in  NUM_CPU  per-core write enable
m_adr_i  in  NUM_CPU*32  per-core address, slot k at [32k+31:32k]
m_dat_i  in  NUM_CPU*32  per-core write data
m_dat_o  out  32  read data, broadcast to all cores
m_ack_o  out  NUM_CPU  per-core one-cycle ack
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe (equal to s_cyc_o)
s_we_o  out  1  slave write enable
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ack
grant_o  out  SEL_W  index of current or last granted core
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; round-robin pointer rr=0; watchdog=0.
- FSM states: IDLE, BUS, RESP.
- IDLE: if any m_cyc_i bit is set, choose the first requester at or after rr (wrapping modulo NUM_CPU). Register grant, latch we/adr/dat of that slot, go to BUS. s_cyc_o rises on the same edge. Request-to-s_cyc latency is 1 cycle.
- BUS: s_cyc/stb/we/adr/dat stay stable from the latched copy. The watchdog increments each cycle.
  - s_ack_i=1: latch s_dat_i into m_dat_o (writes latch too; cores ignore it), drop s_cyc_o, set m_ack_o[grant]=1, go to RESP.
  - Watchdog reaches TIMEOUT_CYC with no ack: same as ack, but m_dat_o=TIMEOUT_DATA and timeout_o pulses.
  - Granted core drops m_cyc_i (core stopped or reset mid-access): abort. s_cyc_o drops next edge, no ack, return to IDLE, rr=grant+1.
  - Abort has priority below a simultaneous s_ack_i. The ack is still issued, and the core ignores it.
- RESP: m_ack_o is high for exactly this one cycle. rr=grant+1 mod NUM_CPU, watchdog=0, go to IDLE. Requests are not sampled in RESP, so the same core's back-to-back request is re-arbitrated in IDLE and other waiting cores get priority.
- The minimum transaction is 3 cycles (IDLE→BUS→RESP) with a 0-wait slave: request at edge 0, s_cyc at edge 1, s_ack sampled at edge 2, m_ack high during cycle 2–3.
- m_dat_o holds its value until the next ack or timeout. m_ack_o is never high for more than one core or more than one cycle.
- The watchdog is 16 bits and saturates. TIMEOUT_CYC counts BUS cycles after the first.
- An s_ack_i seen outside BUS is ignored.
- Fairness: with all cores requesting continuously, grants go 0,1,2,3,0,… The worst-case wait for any core is NUM_CPU-1 transactions.

Decomposition:
- Shared definitions (existing define.v): DataWidth, CpuNumWidth, and new constants ARB_IDLE/ARB_BUS/ARB_RESP (2-bit state encoding).
- Sub-module rr_arbiter_pick: combinational round-robin priority encoder. Inputs: req vector and rr pointer. Outputs: grant index and valid. It is reused by the planned instruction-fetch arbiter.

Test Plan:
1. Single read: core 2 issues cyc, we=0, adr=0x100; the slave acks after 2 waits with 0xCAFEF00D. Expect s_cyc one cycle after request, m_ack_o=4'b0100 for one cycle, m_dat_o=0xCAFEF00D, grant_o=2.
2. Contention: all 4 cores request continuously with a 0-wait slave. Expect grant sequence 0,1,2,3,0, each transaction 3 cycles, exactly one m_ack_o bit per transaction.
3. Write: core 1 issues we=1, adr=0x20, dat=0x12345678. Expect s_we_o=1, s_adr_o=0x20, s_dat_o=0x12345678 stable until s_ack_i, then m_ack_o=4'b0010.
4. Timeout: TIMEOUT_CYC=8 and the slave never acks. Expect timeout_o pulse and m_ack_o for the requester with m_dat_o=0 nine cycles after s_cyc_o rises, then IDLE.
5. Abort: core 0 drops cyc in BUS before ack. Expect s_cyc_o low next cycle, no m_ack_o, and core 1's pending request granted next (rr advanced).
6. Reset mid-BUS: assert rst asynchronously while s_cyc_o=1. Expect all outputs 0 immediately, without waiting for a clock edge, and first grant after release going to core 0.
